nes_joypad: RTL
===============

NES_JOYPAD -- requirements
Module: nes_joypad

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide TURBO_HALF, default 2: frame ticks per turbo half-period; legal range 1..15.
Ports (name direction width meaning):
REQ-002 SHALL provide clk  input  1  single system clock; all state on rising edge.
REQ-003 SHALL provide reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL provide ce  input  1  NES clock enable; qualifies all protocol and turbo state.
REQ-005 SHALL provide joypad_strobe  input  1  latch/reload request from the NES core ($4016 bit0).
REQ-006 SHALL provide joypad_clock  input  2  per-port read pulse from the NES core; bit n belongs to port n.
REQ-007 SHALL provide joypad_data  output  2  serial button bit to the NES core; bit n = port n.
REQ-008 SHALL provide buttons_p1  input  8  port-0 raw buttons, asynchronous; bit0..7 = A,B,Select,Start,Up,Down,Left,Right; 1 = pressed.
REQ-009 SHALL provide buttons_p2  input  8  port-1 raw buttons, same encoding.
REQ-010 SHALL provide turbo_en  input  4  turbo enable {p2B,p2A,p1B,p1A}, static or quasi-static.
REQ-011 SHALL provide frame_tick  input  1  one-clk pulse per video frame.

Function
REQ-012 buttons_p1/p2 SHALL each pass a 2-flop synchronizer clocked every clk, independent of ce.
REQ-013 Opposing directions SHALL be masked after sync: Up&Down both pressed -> both 0; Left&Right both pressed -> both 0; other bits unaffected.
REQ-014 Turbo counter (4 bits) SHALL increment on clk edges with ce=1 and frame_tick=1; on reaching TURBO_HALF-1 it SHALL wrap to 0 and toggle turbo_phase.
REQ-015 frame_tick with ce=0 SHALL be ignored (no count).
REQ-016 Effective A/B bit SHALL be synced_bit AND (NOT turbo_en bit OR turbo_phase); other bits = masked synced bits.
REQ-017 Per port: one 8-bit shift register; joypad_data[n] SHALL equal its bit0 combinationally from the register (no extra stage).
REQ-018 On ce=1 with joypad_strobe=1, both shift registers SHALL reload with effective buttons every such cycle (continuous reload; data reads A while strobe held).
REQ-019 Strobe SHALL take priority: joypad_clock edges during strobe=1 SHALL not shift.
REQ-020 Per port, previous joypad_clock[n] SHALL be registered on ce=1 cycles only; rising edge = current 1 and previous 0.
REQ-021 On ce=1, strobe=0, rising edge on joypad_clock[n]: register n SHALL shift right one bit, shifting 1 into bit7.
REQ-022 After 8 shifts joypad_data[n] SHALL read 1 on every further shift until next reload.
REQ-023 Simultaneous edges on both ports SHALL shift both registers independently in the same cycle.
REQ-024 joypad_clock held high SHALL cause exactly one shift.
REQ-025 Strobe falling edge SHALL cause no action; registers hold last loaded value.
REQ-026 With ce=0, shift registers, edge registers, turbo counter and turbo_phase SHALL hold.
REQ-027 Latency, ce=1 continuous, strobe=1: button change set up before edge k SHALL appear in the shift register (and on joypad_data if A) after edge k+2.

Reset
REQ-028 reset=0 SHALL immediately clear sync flops, shift registers (8'h00, joypad_data=2'b00), edge registers, turbo counter (0) and turbo_phase (0), regardless of clk.
REQ-029 Reset asserted mid-read SHALL abort the read; after release first data SHALL come only from a new strobe reload.
REQ-030 Reset release SHALL be synchronized by the integrator; block requires no further sequencing.

Verification
REQ-031 buttons_p1=8'h09 (A,Start), strobe pulse, then 10 joypad_clock[0] pulses -> joypad_data[0] reads 1,0,0,1,0,0,0,0 after strobe then per pulse, then 1,1,1.
REQ-032 buttons_p1=8'h30 (Up+Down), buttons_p2=8'hC0 (Left+Right), strobe, 8 reads each port -> all bits 0 on both ports.
REQ-033 turbo_en=4'b0001, TURBO_HALF=2, A held, strobe+read A once per frame_tick -> A reads 0,0,1,1,0,0,1,1 (phase starts 0, toggles every 2 ticks); with ce=0 on a tick that tick is not counted.
REQ-034 strobe held 1, toggle joypad_clock[0] 5 times -> joypad_data[0] stays = A; buttons A change while strobe held -> data follows after 3 clks.
REQ-035 After 3 shifts on port 0 only, assert reset -> joypad_data=2'b00 at once; release, read without strobe -> shifts 1s into bit7, data 0 for 8 reads then 1.
REQ-036 p1=8'h01, p2=8'h02, strobe, simultaneous joypad_clock=2'b11 pulses -> data sequences 1,0,... on port 0 and 0,1,0,... on port 1 in lockstep.

Source files
------------

// File: rtl/nes_joypad.sv
// NES controller port pair: synchronizes raw buttons, masks opposing
// directions, applies frame-based turbo to A/B and serializes through
// the standard 4016/4017 strobe/clock shift-register protocol.
module nes_joypad #(
    parameter int unsigned TURBO_HALF = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       joypad_strobe,
    input  logic [1:0] joypad_clock,
    output logic [1:0] joypad_data,
    input  logic [7:0] buttons_p1,
    input  logic [7:0] buttons_p2,
    input  logic [3:0] turbo_en,
    input  logic       frame_tick
);

    localparam int unsigned BTN_W = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned PORTS = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TURBO_HALF - 1);

    logic [BTN_W-1:0]            p1_meta;
    logic [BTN_W-1:0]            p1_sync;
    logic [BTN_W-1:0]            p2_meta;
    logic [BTN_W-1:0]            p2_sync;
    logic [BTN_W-1:0]            eff_p1;
    logic [BTN_W-1:0]            eff_p2;
    logic [CNT_W-1:0]            turbo_cnt;
    logic                        turbo_phase;
    logic [PORTS-1:0][BTN_W-1:0] shreg;
    logic [PORTS-1:0]            clk_prev;
    logic [PORTS-1:0]            clk_rise;

    // Clear both bits of an opposing direction pair when both are pressed.
    function automatic logic [BTN_W-1:0] mask_dirs(input logic [BTN_W-1:0] b);
        logic [BTN_W-1:0] r;
        r = b;
        if (b[4] && b[5]) r[5:4] = 2'b00;
        if (b[6] && b[7]) r[7:6] = 2'b00;
        return r;
    endfunction

    // Two-flop synchronizers for the asynchronous button inputs, free-running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1_meta <= '0;
            p1_sync <= '0;
            p2_meta <= '0;
            p2_sync <= '0;
        end else begin
            p1_meta <= buttons_p1;
            p1_sync <= p1_meta;
            p2_meta <= buttons_p2;
            p2_sync <= p2_meta;
        end
    end

    // Turbo phase generator: toggles every TURBO_HALF qualified frame ticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            turbo_cnt   <= '0;
            turbo_phase <= 1'b0;
        end else if (ce && frame_tick) begin
            if (turbo_cnt == CNT_LAST) begin
                turbo_cnt   <= '0;
                turbo_phase <= ~turbo_phase;
            end else begin
                turbo_cnt <= turbo_cnt + CNT_W'(1);
            end
        end
    end

    // Effective buttons: direction masking plus turbo gating of A and B.
    always_comb begin
        eff_p1 = mask_dirs(p1_sync);
        eff_p2 = mask_dirs(p2_sync);
        if (turbo_en[0] && !turbo_phase) eff_p1[0] = 1'b0;
        if (turbo_en[1] && !turbo_phase) eff_p1[1] = 1'b0;
        if (turbo_en[2] && !turbo_phase) eff_p2[0] = 1'b0;
        if (turbo_en[3] && !turbo_phase) eff_p2[1] = 1'b0;
    end

    assign clk_rise = joypad_clock & ~clk_prev;

    // Serial protocol: continuous reload while strobed, else shift on read edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            clk_prev <= '0;
        end else if (ce) begin
            clk_prev <= joypad_clock;
            if (joypad_strobe) begin
                shreg[0] <= eff_p1;
                shreg[1] <= eff_p2;
            end else begin
                for (int n = 0; n < PORTS; n++) begin
                    if (clk_rise[n]) shreg[n] <= {1'b1, shreg[n][BTN_W-1:1]};
                end
            end
        end
    end

    // Serial output straight from bit0 of each shift register.
    assign joypad_data = {shreg[1][0], shreg[0][0]};

endmodule
